// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the parametrised UART transmitter and receiver.
// Contents:
//   uart_state_e   frame state encoding (IDLE, START, DATA, PARITY, STOP)
//   *_MIN / *_MAX  legal ranges for DATA_BITS and STOP_BITS
//   parity_bit()   parity over a zero-extended character
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  // Unused upper bits must be zero so they do not disturb the result.
  function automatic logic parity_bit(input logic [DATA_BITS_MAX-1:0] data,
                                      input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// uart_tx_param_if: valid/ready character handshake between a host and the UART transmitter.
// Signals:
//   in_valid  host presents a character
//   in_data   character, DATA_BITS wide
//   in_ready  transmitter can accept a character
// Modports: master = host side, slave = transmitter side.
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 in_valid;
  logic [DATA_BITS-1:0] in_data;
  logic                 in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period divider.
// Counts 0..DIV-1 while run is high and emits tick in the last count of each period.
// Ports:
//   clk, rst  system clock, asynchronous active-high reset
//   run       count enable; the counter is held at 0 while low
//   restart   synchronous restart to count 0 (takes priority over run)
//   tick      high for one clock at the end of each DIV-clock period
module uart_baud_gen #(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_r;

  // Divider counter: restart or idle forces 0, otherwise wrap at LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (restart || !run) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_r == LAST) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // With DIV=1 the counter stays at 0 == LAST, so tick is high every running clock.
  assign tick = run && !restart && (cnt_r == LAST);

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter.
// Frame: START(0), DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits(1).
// Ports:
//   clk, rst  system clock, asynchronous active-high reset
//   en        transmit enable, gates acceptance of new characters only
//   host      valid/ready character handshake (slave side)
//   out       registered serial line, idle high
//   busy      frame in progress
//   done      one-clock pulse when the last stop bit completes
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  uart_tx_param_if.slave host,
  output logic           out,
  output logic           busy,
  output logic           done
);

  if ((DATA_BITS < DATA_BITS_MIN) || (DATA_BITS > DATA_BITS_MAX)) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS out of range");
  end
  if ((STOP_BITS < STOP_BITS_MIN) || (STOP_BITS > STOP_BITS_MAX)) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS out of range");
  end
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("uart_tx_param: CLK_DIV must be >= 1");
  end

  uart_state_e          state_r, state_s;
  logic [3:0]           bit_cnt_r, bit_cnt_s;
  logic [DATA_BITS-1:0] shift_r, shift_s;
  logic                 parity_r, parity_s;
  logic                 out_r, out_s;
  logic                 busy_r, busy_s;
  logic                 done_r, done_s;
  logic                 ready_r;
  logic                 restart_s;
  logic                 run_s;
  logic                 tick_s;
  logic                 xfer_s;
  logic [DATA_BITS-1:0] data_s;

  assign data_s = host.in_data;
  assign xfer_s = host.in_valid && ready_r && en;
  assign run_s  = (state_r != IDLE);

  uart_baud_gen #(.DIV(CLK_DIV)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .run     (run_s),
    .restart (restart_s),
    .tick    (tick_s)
  );

  // Next-state and next-output logic; out_s is the value the line takes on the next edge.
  always_comb begin
    state_s   = state_r;
    bit_cnt_s = bit_cnt_r;
    shift_s   = shift_r;
    parity_s  = parity_r;
    out_s     = out_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    restart_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (xfer_s) begin
          state_s   = START;
          shift_s   = data_s;
          parity_s  = parity_bit(DATA_BITS_MAX'(data_s), PARITY_ODD != 0);
          bit_cnt_s = 4'd0;
          out_s     = 1'b0;
          busy_s    = 1'b1;
          restart_s = 1'b1;
        end else begin
          out_s  = 1'b1;
          busy_s = 1'b0;
        end
      end
      START: begin
        if (tick_s) begin
          state_s = DATA;
          out_s   = shift_r[0];
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        // The register shifts right as bits go out, so the next bit is always shift_r[1].
        if (tick_s) begin
          shift_s = shift_r >> 1;
          if (bit_cnt_r == 4'(DATA_BITS - 1)) begin
            bit_cnt_s = 4'd0;
            if (PARITY_EN != 0) begin
              state_s = PARITY;
              out_s   = parity_r;
            end else begin
              state_s = STOP;
              out_s   = 1'b1;
            end
          end else begin
            bit_cnt_s = bit_cnt_r + 4'd1;
            out_s     = shift_r[1];
          end
        end else begin
          state_s = DATA;
        end
      end
      PARITY: begin
        if (tick_s) begin
          state_s   = STOP;
          bit_cnt_s = 4'd0;
          out_s     = 1'b1;
        end else begin
          state_s = PARITY;
        end
      end
      STOP: begin
        if (tick_s) begin
          if (bit_cnt_r == 4'(STOP_BITS - 1)) begin
            state_s   = IDLE;
            bit_cnt_s = 4'd0;
            busy_s    = 1'b0;
            done_s    = 1'b1;
          end else begin
            bit_cnt_s = bit_cnt_r + 4'd1;
          end
          out_s = 1'b1;
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s   = IDLE;
        bit_cnt_s = 4'd0;
        out_s     = 1'b1;
        busy_s    = 1'b0;
      end
    endcase
  end

  // State and output registers; ready is set for any clock that will be spent in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      bit_cnt_r <= 4'd0;
      shift_r   <= {DATA_BITS{1'b0}};
      parity_r  <= 1'b0;
      out_r     <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ready_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      bit_cnt_r <= bit_cnt_s;
      shift_r   <= shift_s;
      parity_r  <= parity_s;
      out_r     <= out_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      ready_r   <= (state_s == IDLE);
    end
  end

  assign out           = out_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign host.in_ready = ready_r;

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: four transmitter configurations driven side by side.
// Stimulus pushes each accepted character into a per-DUT queue; a monitor per DUT
// decodes the serial line cycle by cycle against a frame model built from the character.
module tb_uart_tx_param;

  localparam int N = 4;
  localparam int DIVS  [N] = '{4, 2, 3, 1};
  localparam int NB    [N] = '{8, 7, 8, 7};
  localparam int PE    [N] = '{0, 1, 0, 1};
  localparam int PO    [N] = '{0, 0, 0, 1};
  localparam int NS    [N] = '{1, 1, 2, 1};
  localparam int FIRST [N] = '{'hA5, 'h35, 'h00, 'h35};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vld  [N];
  logic [8:0] dat  [N];
  logic       en_v [N];
  wire        rdy    [N];
  wire        out_v  [N];
  wire        busy_v [N];
  wire        done_v [N];

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int unsigned exp_q [N][$];
  bit          in_frame  [N];
  int          gap       [N];
  int          prev_done [N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : g_dut
    uart_tx_param_if #(.DATA_BITS(NB[g])) ifc ();
    assign ifc.in_valid = vld[g];
    assign ifc.in_data  = dat[g][NB[g]-1:0];
    assign rdy[g]       = ifc.in_ready;

    uart_tx_param #(
      .CLK_DIV(DIVS[g]), .DATA_BITS(NB[g]), .PARITY_EN(PE[g]),
      .PARITY_ODD(PO[g]), .STOP_BITS(NS[g])
    ) dut (
      .clk(clk), .rst(rst), .en(en_v[g]), .host(ifc),
      .out(out_v[g]), .busy(busy_v[g]), .done(done_v[g])
    );

    initial monitor(g);
  end

  task automatic check(input bit ok, input string name, input int k, input int act, input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0h expected=%0h", name, k, act, exp);
    end
  endtask

  function automatic int frame_len(input int k);
    return 1 + NB[k] + PE[k] + NS[k];
  endfunction

  // Expected line level for frame position j of character d.
  function automatic bit model_bit(input int k, input int d, input int j);
    if (j == 0) return 1'b0;
    if (j <= NB[k]) return bit'((d >> (j - 1)) & 1);
    if (PE[k] != 0 && j == NB[k] + 1) return bit'(($countones(d) % 2) ^ PO[k]);
    return 1'b1;
  endfunction

  task automatic monitor(input int k);
    int d, st, len;
    bit ok, aborted;
    logic [3:0] got, want;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame[k] = 1'b0;
        continue;
      end
      check(done_v[k] === 1'b0, "idle_done_low", k, int'(done_v[k]), 0);
      if (out_v[k] === 1'b0) begin
        in_frame[k] = 1'b1;
        st = cyc;
        gap[k] = st - prev_done[k];
        if (exp_q[k].size() == 0) begin
          check(1'b0, "unexpected_frame", k, 1, 0);
          d = 0;
        end else begin
          d = int'(exp_q[k].pop_front());
        end
        len = frame_len(k);
        aborted = 1'b0;
        for (int j = 0; j < len; j++) begin
          ok   = 1'b1;
          want = {3'b001, model_bit(k, d, j)};
          got  = want;
          for (int c = 0; c < DIVS[k]; c++) begin
            if (j != 0 || c != 0) @(negedge clk);
            if (rst) begin
              aborted = 1'b1;
              break;
            end
            if ({done_v[k], rdy[k], busy_v[k], out_v[k]} !== want) begin
              ok  = 1'b0;
              got = {done_v[k], rdy[k], busy_v[k], out_v[k]};
            end
          end
          if (aborted) break;
          check(ok, $sformatf("frame_bit%0d {done,rdy,busy,out}", j), k, int'(got), int'(want));
        end
        if (aborted) begin
          in_frame[k] = 1'b0;
          continue;
        end
        @(negedge clk);
        if (rst) begin
          in_frame[k] = 1'b0;
          continue;
        end
        check({done_v[k], busy_v[k], out_v[k], rdy[k]} === 4'b1011, "done_cycle {done,busy,out,rdy}",
              k, int'({done_v[k], busy_v[k], out_v[k], rdy[k]}), 'b1011);
        check(cyc - st == len * DIVS[k], "frame_len_clks", k, cyc - st, len * DIVS[k]);
        prev_done[k] = cyc;
        in_frame[k]  = 1'b0;
      end
    end
  endtask

  // Present d; push it as expected on the clock that will transfer it.
  task automatic send(input int k, input int d, input bit hold);
    int n;
    n = 0;
    vld[k] = 1'b1;
    dat[k] = 9'(d);
    while (!(rdy[k] === 1'b1 && en_v[k]) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      check(1'b0, "send_timeout", k, n, 0);
      vld[k] = 1'b0;
    end else begin
      exp_q[k].push_back(int'(d & ((1 << NB[k]) - 1)));
      @(posedge clk);
      #1;
      if (!hold) vld[k] = 1'b0;
    end
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while ((exp_q[k].size() != 0 || in_frame[k]) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(n < 5000, "drain_timeout", k, n, 0);
  endtask

  task automatic run_seq(input int k);
    bit h;
    send(k, FIRST[k], 1'b0);
    wait_idle(k);
    send(k, 'h11, 1'b1);
    send(k, 'h22, 1'b0);
    wait_idle(k);
    check(gap[k] == 1, "b2b_gap_clks", k, gap[k], 1);
    for (int i = 0; i < 6; i++) begin
      h = (i < 5) ? bit'($urandom_range(0, 1)) : 1'b0;
      send(k, int'($urandom_range(0, 511)), h);
      if (!h) repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    wait_idle(k);
  endtask

  initial begin
    int bad;
    for (int k = 0; k < N; k++) begin
      vld[k] = 1'b0;
      dat[k] = 9'd0;
      en_v[k] = 1'b1;
      in_frame[k] = 1'b0;
      gap[k] = 0;
      prev_done[k] = -1000;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++)
      check({done_v[k], busy_v[k], out_v[k]} === 3'b001, "reset_state {done,busy,out}", k,
            int'({done_v[k], busy_v[k], out_v[k]}), 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) check(rdy[k] === 1'b1, "ready_after_reset", k, int'(rdy[k]), 1);

    fork
      run_seq(0);
      run_seq(1);
      run_seq(2);
      run_seq(3);
    join

    // Reset in the middle of data bit 3 of 0xFF on the 8N1 instance.
    send(0, 'hFF, 1'b0);
    repeat (4 * DIVS[0] + 1) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check({done_v[0], busy_v[0], out_v[0]} === 3'b001, "async_reset {done,busy,out}", 0,
          int'({done_v[0], busy_v[0], out_v[0]}), 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check(rdy[0] === 1'b1, "ready_after_abort", 0, int'(rdy[0]), 1);
    send(0, 'h5A, 1'b0);
    wait_idle(0);

    // Valid held while disabled: nothing may start.
    en_v[0] = 1'b0;
    vld[0]  = 1'b1;
    dat[0]  = 9'h077;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (out_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || rdy[0] !== 1'b1) bad++;
    end
    check(bad == 0, "en_holdoff_bad_clks", 0, bad, 0);

    // Enable for one transfer, then drop it: frame completes, no further frames.
    en_v[0] = 1'b1;
    send(0, 'h3C, 1'b1);
    en_v[0] = 1'b0;
    wait_idle(0);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (out_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) bad++;
    end
    check(bad == 0, "idle_after_en_drop_bad_clks", 0, bad, 0);
    vld[0]  = 1'b0;
    en_v[0] = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 0);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised 8N1-successor UART transmitter. It serialises one character per transaction with a configurable frame:
- 5-9 data bits, LSB first
- optional even/odd parity
- 1 or 2 stop bits

Bit timing comes from an internal clocks-per-bit divider, so the block runs on the system clock instead of a pre-divided baud clock. It sits between a byte-producing host (valid/ready handshake) and the tx pad. It is the transmit half of the parametrised UART pair.

Parameters:
- CLK_DIV, default 16: system clocks per serial bit; must be >= 1; divider counter width is $clog2(CLK_DIV) (min 1).
- DATA_BITS, default 8: data bits per frame, legal 5..9; elaboration error otherwise.
- PARITY_EN, default 0: 1 = append a parity bit after the data bits.
- PARITY_ODD, default 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
- STOP_BITS, default 1: legal 1 or 2; elaboration error otherwise.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- en  input  1  transmit enable; gates acceptance of new frames only
- in_valid  input  1  host presents a character
- in_data  input  DATA_BITS  character to send
- in_ready  output  1  block can accept a character (high only in IDLE)
- out  output  1  serial tx line, registered, idle high
- busy  output  1  frame in progress (START through last STOP)
- done  output  1  one-cycle pulse at frame completion

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values (asserted asynchronously, mid-frame included):
  - out=1, busy=0, done=0, state=IDLE, bit counter=0, divider=0, shift register=0.
  - A frame aborted by reset produces no done pulse.
  - in_ready=1 from the first edge after rst deasserts.
- States and transitions:
  - IDLE → START → DATA → PARITY (only if PARITY_EN) → STOP → IDLE.
  - Each state holds one bit per CLK_DIV clocks; STOP holds STOP_BITS*CLK_DIV clocks.
- Handshake:
  - Transfer occurs on a rising edge where in_valid & in_ready & en.
  - On that edge: in_data is latched into the shift register, parity is computed and latched, state<=START, out<=0, busy<=1, divider<=0.
  - in_data may change freely after the transfer edge.
  - in_valid while en=0 is held off; no transfer, in_ready stays as defined.
- Timing:
  - out changes only on bit boundaries: the edge where the divider reaches CLK_DIV-1 advances the bit and reloads the divider to 0.
  - Frame length from transfer edge to done edge = (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLK_DIV clocks exactly.
- DATA state:
  - Sends bit i of the latched data for i = 0..DATA_BITS-1.
  - The counter wraps to 0 on leaving DATA.
- Parity bit:
  - Even: XOR of all data bits.
  - Odd: inverted XOR.
- STOP state: out=1. On the final boundary edge, state<=IDLE, busy<=0, done<=1.
- done deasserts on the next edge.
- in_ready is high in the done cycle. A continuously held in_valid is therefore accepted on the edge after done, which gives one extra idle-high clock between frames (min inter-frame gap = 1 clk).
- en deasserted mid-frame: the current frame completes normally; no new frame starts.
- CLK_DIV=1: one bit per clock; all rules above still hold.

Decomposition:
- Shared package uart_pkg:
  - state encoding enum (IDLE, START, DATA, PARITY, STOP), shared with the receiver
  - parity function (data, odd) → bit
  - legal-range constants for DATA_BITS/STOP_BITS
- One sub-module, uart_baud_gen:
  - free-running-when-enabled divider with sync restart input and a bit_tick output
  - reused by the receiver with an oversampling divisor

Test Plan:
- 8N1, CLK_DIV=4, send 0xA5 → out: start 0, then 1,0,1,0,0,1,0,1 (LSB first), stop 1; each bit 4 clks; done pulses exactly 40 clks after the transfer edge; busy high 40 clks.
- DATA_BITS=7, PARITY_EN=1, PARITY_ODD=0, send 0x35 (four ones) → parity bit 0; PARITY_ODD=1 → parity bit 1; frame 10 bits.
- STOP_BITS=2, CLK_DIV=3, send 0x00 → line high for 6 clks after the last data bit before done; total frame 33 clks.
- in_valid held high with 0x11 then 0x22 → two frames; second start bit falls exactly 1 clk after the first done; in_ready low throughout each frame.
- Assert rst during DATA bit 3 of 0xFF → out=1, busy=0 immediately (asynchronous); no done pulse; next frame after release transmits correctly.
- en=0 with in_valid=1 → no transfer, out stays 1 for 100 clks. Drop en mid-frame → the frame completes with a done pulse, then the block stays idle.
